scie_pipelined: RTL and testbench



---
 rtl/scie_pipelined.sv | 172 +++++++++++++++++
 tb/tb_scie_pipelined.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scie_pipelined.sv
// ============================================================================
// Module   : scie_pipelined
// Purpose  : Pipelined 5-tap complex FIR filter used as a RISC-V custom
//            instruction execution unit. SETCOEF loads a coefficient, PUSH
//            shifts a complex sample into the delay line and READ returns
//            the scaled filter output.
// Ports    : clock, reset          - clock / async active-high reset
//            io_valid, io_insn     - instruction strobe and word (opcode [6:0])
//            io_rs1_real/imag      - complex operand (coefficient or sample)
//            io_rs2                - coefficient index for SETCOEF
//            io_rd_real/imag       - registered complex result
// Config   : SCIE_SATURATE_EN - clamp results to 32-bit signed range instead
//            of wrapping to the low 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scie_pipelined #(
    parameter int NTAPS     = 5,
    parameter int FRAC_BITS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_valid,
    input  logic [31:0]        io_insn,
    input  logic signed [31:0] io_rs1_real,
    input  logic signed [31:0] io_rs1_imag,
    input  logic [31:0]        io_rs2,
    output logic signed [31:0] io_rd_real,
    output logic signed [31:0] io_rd_imag
);

    localparam logic [6:0] c_op_setcoef = 7'h0B;
    localparam logic [6:0] c_op_push    = 7'h2B;
    localparam logic [6:0] c_op_read    = 7'h5B;

    localparam logic signed [67:0] c_rd_max = 68'sd2147483647;
    localparam logic signed [67:0] c_rd_min = -68'sd2147483648;

    logic signed [31:0] coef_real_q [NTAPS];
    logic signed [31:0] coef_imag_q [NTAPS];
    logic signed [31:0] coef_real_d [NTAPS];
    logic signed [31:0] coef_imag_d [NTAPS];
    logic signed [31:0] x_real_q    [NTAPS];
    logic signed [31:0] x_imag_q    [NTAPS];
    logic signed [31:0] x_real_d    [NTAPS];
    logic signed [31:0] x_imag_d    [NTAPS];

    logic signed [67:0] acc_real_q, acc_real_d;
    logic signed [67:0] acc_imag_q, acc_imag_d;
    logic signed [31:0] rd_real_q, rd_real_d;
    logic signed [31:0] rd_imag_q, rd_imag_d;

    logic signed [67:0] cr, ci, xr, xi;

    logic is_set, is_push, is_read;
    logic unused_insn;

    assign is_set  = io_valid && (io_insn[6:0] == c_op_setcoef);
    assign is_push = io_valid && (io_insn[6:0] == c_op_push);
    assign is_read = io_valid && (io_insn[6:0] == c_op_read);

    // Only the opcode field is decoded.
    assign unused_insn = ^io_insn[31:7];

    // Scale the accumulated sum once (floor), then fit to 32 bits.
    function automatic logic signed [31:0] fit_rd(input logic signed [67:0] acc);
        logic signed [67:0] s;
        s = acc >>> FRAC_BITS;
`ifdef SCIE_SATURATE_EN
        if (s > c_rd_max)
            return c_rd_max[31:0];
        else if (s < c_rd_min)
            return c_rd_min[31:0];
        else
            return s[31:0];
`else
        return s[31:0];
`endif
    endfunction

    // Stage 1: coefficient and delay-line writes.
    always_comb begin
        coef_real_d = coef_real_q;
        coef_imag_d = coef_imag_q;
        x_real_d    = x_real_q;
        x_imag_d    = x_imag_q;
        if (is_set) begin
            // Out-of-range indices match no tap and are dropped.
            for (int k = 0; k < NTAPS; k++) begin
                if (io_rs2 == k) begin
                    coef_real_d[k] = io_rs1_real;
                    coef_imag_d[k] = io_rs1_imag;
                end
            end
        end
        if (is_push) begin
            x_real_d[0] = io_rs1_real;
            x_imag_d[0] = io_rs1_imag;
            for (int k = 1; k < NTAPS; k++) begin
                x_real_d[k] = x_real_q[k-1];
                x_imag_d[k] = x_imag_q[k-1];
            end
        end
    end

    // Stage 2: full-precision complex dot product of the registered state.
    // Operands are sign-extended to the accumulator width so every product
    // and partial sum is exact.
    always_comb begin
        acc_real_d = '0;
        acc_imag_d = '0;
        cr = '0;
        ci = '0;
        xr = '0;
        xi = '0;
        for (int k = 0; k < NTAPS; k++) begin
            cr = 68'(coef_real_q[k]);
            ci = 68'(coef_imag_q[k]);
            xr = 68'(x_real_q[k]);
            xi = 68'(x_imag_q[k]);
            acc_real_d = acc_real_d + (cr * xr) - (ci * xi);
            acc_imag_d = acc_imag_d + (cr * xi) + (ci * xr);
        end
    end

    // Stage 3: READ samples the accumulator register; otherwise rd holds.
    always_comb begin
        rd_real_d = rd_real_q;
        rd_imag_d = rd_imag_q;
        if (is_read) begin
            rd_real_d = fit_rd(acc_real_q);
            rd_imag_d = fit_rd(acc_imag_q);
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                coef_real_q[k] <= '0;
                coef_imag_q[k] <= '0;
                x_real_q[k]    <= '0;
                x_imag_q[k]    <= '0;
            end else begin
                coef_real_q[k] <= coef_real_d[k];
                coef_imag_q[k] <= coef_imag_d[k];
                x_real_q[k]    <= x_real_d[k];
                x_imag_q[k]    <= x_imag_d[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_real_q <= '0;
            acc_imag_q <= '0;
            rd_real_q  <= '0;
            rd_imag_q  <= '0;
        end else begin
            acc_real_q <= acc_real_d;
            acc_imag_q <= acc_imag_d;
            rd_real_q  <= rd_real_d;
            rd_imag_q  <= rd_imag_d;
        end
    end

    assign io_rd_real = rd_real_q;
    assign io_rd_imag = rd_imag_q;

endmodule

`default_nettype wire

// File: tb/tb_scie_pipelined.sv
// ============================================================================
// Module   : tb_scie_pipelined
// Purpose  : Self-checking bench for scie_pipelined. A reference model keeps
//            the coefficient table and the sample history as plain arrays and
//            a queue and evaluates the filter sum directly at READ time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scie_pipelined;

    localparam logic [6:0] OP_SET  = 7'h0B;
    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;

    logic               clock;
    logic               reset;
    logic               io_valid;
    logic [31:0]        io_insn;
    logic signed [31:0] io_rs1_real;
    logic signed [31:0] io_rs1_imag;
    logic [31:0]        io_rs2;
    logic signed [31:0] io_rd_real;
    logic signed [31:0] io_rd_imag;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic signed [31:0] m_cr [5];
    logic signed [31:0] m_ci [5];
    logic signed [31:0] m_xr [$];
    logic signed [31:0] m_xi [$];

    scie_pipelined #(.NTAPS(5), .FRAC_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_valid    (io_valid),
        .io_insn     (io_insn),
        .io_rs1_real (io_rs1_real),
        .io_rs1_imag (io_rs1_imag),
        .io_rs2      (io_rs2),
        .io_rd_real  (io_rd_real),
        .io_rd_imag  (io_rd_imag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_clear();
        m_xr.delete();
        m_xi.delete();
        for (int k = 0; k < 5; k++) begin
            m_cr[k] = 0;
            m_ci[k] = 0;
            m_xr.push_back(0);
            m_xi.push_back(0);
        end
    endfunction

    // Sum of coef[k]*x[k] using exact 64-bit products accumulated in 68 bits.
    function automatic logic signed [67:0] model_sum(input bit imag);
        logic signed [67:0] acc;
        longint p1, p2;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (!imag) begin
                p1 = longint'(m_cr[k]) * longint'(m_xr[k]);
                p2 = longint'(m_ci[k]) * longint'(m_xi[k]);
                acc = acc + 68'(p1) - 68'(p2);
            end else begin
                p1 = longint'(m_cr[k]) * longint'(m_xi[k]);
                p2 = longint'(m_ci[k]) * longint'(m_xr[k]);
                acc = acc + 68'(p1) + 68'(p2);
            end
        end
        return acc;
    endfunction

    function automatic logic signed [31:0] model_rd(input bit imag);
        logic signed [67:0] s;
        s = model_sum(imag) >>> 8;
`ifdef SCIE_SATURATE_EN
        if (s > 68'sd2147483647)  return 32'sh7FFFFFFF;
        if (s < -68'sd2147483648) return 32'sh80000000;
`endif
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one instruction for one cycle (random upper insn bits), then
    // update the model for what that edge did.
    task automatic issue(input logic v, input logic [6:0] op,
                         input logic signed [31:0] r, input logic signed [31:0] i,
                         input logic [31:0] idx);
        io_valid    = v;
        io_insn     = $urandom;
        io_insn[6:0] = op;
        io_rs1_real = r;
        io_rs1_imag = i;
        io_rs2      = idx;
        @(posedge clock);
        #1;
        io_valid = 1'b0;
        io_insn  = 32'h0;
        if (v && op == OP_SET && idx < 5) begin
            m_cr[idx] = r;
            m_ci[idx] = i;
        end
        if (v && op == OP_PUSH) begin
            m_xr.push_front(r);
            m_xi.push_front(i);
            void'(m_xr.pop_back());
            void'(m_xi.pop_back());
        end
    endtask

    task automatic idle();
        issue(1'b0, 7'h00, 0, 0, 0);
    endtask

    task automatic read_expect(input string tag, input logic signed [31:0] er,
                               input logic signed [31:0] ei);
        issue(1'b1, OP_READ, $urandom, $urandom, $urandom);
        check({tag, "_re"}, io_rd_real, er);
        check({tag, "_im"}, io_rd_imag, ei);
    endtask

    task automatic push_read(input string tag, input logic signed [31:0] r,
                             input logic signed [31:0] i);
        issue(1'b1, OP_PUSH, r, i, $urandom);
        idle();
        read_expect(tag, model_rd(0), model_rd(1));
    endtask

    task automatic load_plan_coefs();
        issue(1'b1, OP_SET, 8636, 4720, 0);
        issue(1'b1, OP_SET, -8113, 7752, 1);
        issue(1'b1, OP_SET, -10134, -11600, 2);
        issue(1'b1, OP_SET, 10743, 88, 3);
        issue(1'b1, OP_SET, 1182, 4549, 4);
    endtask

    initial begin
        logic signed [31:0] pr, pi;
        io_valid = 0; io_insn = 0; io_rs1_real = 0; io_rs1_imag = 0; io_rs2 = 0;
        model_clear();
        reset = 1'b1;
        #12;
        check("reset_re", io_rd_real, 0);
        check("reset_im", io_rd_imag, 0);
        @(negedge clock);
        reset = 1'b0;

        // Directed vectors
        load_plan_coefs();
        push_read("p1", 1556, -10869);
        check("p1_lit_re", io_rd_real, 252887);
        check("p1_lit_im", io_rd_imag, -337971);
        push_read("p2", 6303, -3592);
        check("p2_lit_re", io_rd_real, 558670);
        check("p2_lit_im", io_rd_imag, 386609);
        push_read("p3", 7010, 10767);
        check("p3_lit_re", io_rd_real, -607117);
        check("p3_lit_im", io_rd_imag, 1156916);
        push_read("p4", 8628, 12119);
        check("p4_lit_re", io_rd_real, -823818);
        check("p4_lit_im", io_rd_imag, -160038);

        // Held rd across idle cycles
        idle(); idle();
        check("hold_re", io_rd_real, -823818);
        check("hold_im", io_rd_imag, -160038);

        // Invalid PUSH, then out-of-range SETCOEF indices
        issue(1'b0, OP_PUSH, 12345, -999, 0);
        idle();
        read_expect("nopush", -823818, -160038);
        issue(1'b1, OP_SET, 77777, 55555, 5);
        issue(1'b1, OP_SET, 77777, 55555, 32'h8000_0000);
        idle();
        read_expect("badidx", -823818, -160038);
        // Unknown opcode does nothing
        issue(1'b1, 7'h33, 4444, 4444, 0);
        idle();
        read_expect("badop", -823818, -160038);

        // READ right after PUSH returns the pre-PUSH value
        pr = model_rd(0);
        pi = model_rd(1);
        issue(1'b1, OP_PUSH, -3000, 2500, 0);
        read_expect("early", pr, pi);
        idle();
        read_expect("late", model_rd(0), model_rd(1));

        // Asynchronous reset mid-operation
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_re", io_rd_real, 0);
        check("async_rst_im", io_rd_imag, 0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        load_plan_coefs();
        push_read("after_rst", 1556, -10869);
        check("after_rst_lit_re", io_rd_real, 252887);
        check("after_rst_lit_im", io_rd_imag, -337971);

        // Randomized full-range operation
        for (int n = 0; n < 24; n++) begin
            int nset, npush;
            nset = $urandom_range(0, 2);
            for (int s = 0; s < nset; s++)
                issue(1'b1, OP_SET, $urandom, $urandom, $urandom_range(0, 6));
            npush = $urandom_range(1, 3);
            for (int s = 0; s < npush; s++)
                issue(1'b1, OP_PUSH, $urandom, $urandom, $urandom);
            idle();
            read_expect($sformatf("rnd%0d", n), model_rd(0), model_rd(1));
        end

        // Overflow of the 32-bit result
        reset = 1'b1;
        #1;
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        issue(1'b1, OP_SET, 32'sh7FFFFFFF, 0, 0);
        push_read("ovf", 32'sh7FFFFFFF, 0);
`ifdef SCIE_SATURATE_EN
        check("ovf_lit_re", io_rd_real, 32'sh7FFFFFFF);
`else
        check("ovf_lit_re", io_rd_real, -32'sd16777216);
`endif
        check("ovf_lit_im", io_rd_imag, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
